// File: rtl/vc_buffer_array.sv
// vc_buffer_array: input-port buffer with one FIFO per virtual channel.
//
// Each VC owns a DEPTH-entry FIFO. Wormhole packet lock is tracked per VC
// from the flit type bits. A new head is refused while a packet is still open
// on that VC. Buffered flits leave through one shared output that is picked
// round-robin across the non-empty VCs.
//
// Ports:
//   clk       rising-edge clock
//   arst      synchronous active-high reset
//   vc_id_i   VC of the incoming flit
//   fdata_i   incoming flit; top two bits are the type (00 head, 11 tail, else body)
//   valid_i   incoming flit valid
//   ready_o   incoming flit accepted this cycle
//   vc_id_o   VC of the outgoing flit (0 when idle)
//   fdata_o   outgoing flit (0 when idle)
//   valid_o   outgoing flit valid
//   ready_i   downstream accepts the outgoing flit
//   ocup_o    per-VC occupancy, VC v at [v*OCC_W +: OCC_W]
//   locked_o  per-VC packet-in-progress flags
//   error_o   one-cycle pulse after a body/tail is accepted on an unlocked VC
module vc_buffer_array #(
    parameter int unsigned FLIT_W = 34,
    parameter int unsigned NUM_VC = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned VC_W   = $clog2(NUM_VC),
    parameter int unsigned OCC_W  = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic [VC_W-1:0]         vc_id_i,
    input  logic [FLIT_W-1:0]       fdata_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [VC_W-1:0]         vc_id_o,
    output logic [FLIT_W-1:0]       fdata_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [NUM_VC*OCC_W-1:0] ocup_o,
    output logic [NUM_VC-1:0]       locked_o,
    output logic                    error_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [OCC_W-1:0] ptr_t;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    ptr_t              wr_ptr_q [NUM_VC];
    ptr_t              wr_ptr_d [NUM_VC];
    ptr_t              rd_ptr_q [NUM_VC];
    ptr_t              rd_ptr_d [NUM_VC];
    logic [FLIT_W-1:0] mem_q    [NUM_VC][DEPTH];

    logic [NUM_VC-1:0] locked_q, locked_d;
    logic              error_q, error_d;
    logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [VC_W-1:0]   gnt_q, gnt_d;
    logic              hold_q, hold_d;

    logic [NUM_VC-1:0] empty, full, in_sel;
    logic              is_head, is_tail;
    logic              sel_ok, sel_full, sel_locked;
    logic              wr_en, rd_en;

    logic [VC_W-1:0]   pick_hi, pick_lo, gnt_new, gnt;
    logic              found_hi;
    logic [FLIT_W-1:0] head_data;

    assign is_head = (fdata_i[FLIT_W-1 -: 2] == 2'b00);
    assign is_tail = (fdata_i[FLIT_W-1 -: 2] == 2'b11);

    // Per-VC status and occupancy.
    always_comb begin
        empty  = '0;
        full   = '0;
        in_sel = '0;
        ocup_o = '0;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            empty[v]  = (wr_ptr_q[v] == rd_ptr_q[v]);
            full[v]   = (wr_ptr_q[v][AW-1:0] == rd_ptr_q[v][AW-1:0]) &&
                        (wr_ptr_q[v][AW] != rd_ptr_q[v][AW]);
            in_sel[v] = (vc_id_i == VC_W'(v));
            ocup_o[v*OCC_W +: OCC_W] = wr_ptr_q[v] - rd_ptr_q[v];
        end
    end

    // Status of the VC addressed by the incoming flit. sel_ok guards vc_id_i
    // values beyond NUM_VC when NUM_VC is not a power of two.
    always_comb begin
        sel_ok     = 1'b0;
        sel_full   = 1'b0;
        sel_locked = 1'b0;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            if (in_sel[v]) begin
                sel_ok     = 1'b1;
                sel_full   = full[v];
                sel_locked = locked_q[v];
            end
        end
    end

    // Acceptance depends only on stored state and the incoming flit, never on
    // ready_i, so a full VC cannot be bypassed by a same-cycle read.
    assign ready_o = ~arst & sel_ok & ~sel_full & ~(is_head & sel_locked);
    assign wr_en   = valid_i & ready_o;

    // Round-robin: lowest non-empty VC at or above rr_ptr, else lowest overall.
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        for (int v = int'(NUM_VC) - 1; v >= 0; v--) begin
            if (!empty[v]) begin
                pick_lo = VC_W'(v);
                if (VC_W'(v) >= rr_ptr_q) begin
                    pick_hi  = VC_W'(v);
                    found_hi = 1'b1;
                end
            end
        end
        gnt_new = found_hi ? pick_hi : pick_lo;
    end

    // A stalled grant stays put so a newly filled VC cannot steal the output.
    assign gnt = hold_q ? gnt_q : gnt_new;

    always_comb begin
        head_data = '0;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            if (gnt == VC_W'(v)) begin
                head_data = mem_q[v][rd_ptr_q[v][AW-1:0]];
            end
        end
    end

    assign valid_o = ~arst & ~(&empty);
    assign fdata_o = valid_o ? head_data : '0;
    assign vc_id_o = valid_o ? gnt : '0;
    assign rd_en   = valid_o & ready_i;

    assign locked_o = locked_q;
    assign error_o  = error_q;

    // Next-state logic.
    always_comb begin
        locked_d = locked_q;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            wr_ptr_d[v] = wr_ptr_q[v] + ptr_t'(wr_en && in_sel[v]);
            rd_ptr_d[v] = rd_ptr_q[v] + ptr_t'(rd_en && (gnt == VC_W'(v)));
            if (wr_en && in_sel[v]) begin
                if (is_head) begin
                    locked_d[v] = 1'b1;
                end else if (is_tail) begin
                    locked_d[v] = 1'b0;
                end
            end
        end
        error_d = wr_en & ~is_head & ~sel_locked;

        rr_ptr_d = rr_ptr_q;
        if (rd_en) begin
            rr_ptr_d = (gnt == VC_W'(NUM_VC - 1)) ? '0 : gnt + VC_W'(1);
        end

        hold_d = valid_o & ~ready_i;
        gnt_d  = gnt;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            for (int v = 0; v < int'(NUM_VC); v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
            end
            locked_q <= '0;
            error_q  <= 1'b0;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            hold_q   <= 1'b0;
        end else begin
            for (int v = 0; v < int'(NUM_VC); v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
            end
            locked_q <= locked_d;
            error_q  <= error_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            hold_q   <= hold_d;
        end
    end

    // Storage needs no reset: contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        for (int v = 0; v < int'(NUM_VC); v++) begin
            if (wr_en && in_sel[v]) begin
                mem_q[v][wr_ptr_q[v][AW-1:0]] <= fdata_i;
            end
        end
    end

endmodule

// File: doc/vc_buffer_array.md
Name: vc_buffer_array

Overview:
Parametrised input-port buffer for the NoC router, replacing the single-VC, fixed-depth buffer. It holds NUM_VC independent FIFOs of DEPTH flits each, one per virtual channel, and tracks wormhole packet lock per VC from the flit type bits. Occupancy is reported per VC. Buffered flits are drained through one shared output with round-robin VC arbitration. It sits between the link input and the route/switch-allocation stage.

Parameters:
FLIT_W, 34, flit width; bits [FLIT_W-1:FLIT_W-2] are the flit type.
NUM_VC, 4, number of virtual channels; range 2..8.
DEPTH, 4, flits per VC FIFO; power of two, at least 2.
VC_W, $clog2(NUM_VC), derived; VC id width.
OCC_W, $clog2(DEPTH)+1, derived; per-VC occupancy width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
arst  in  1  synchronous, active-high reset.
vc_id_i  in  VC_W  VC of the incoming flit.
fdata_i  in  FLIT_W  incoming flit.
valid_i  in  1  incoming flit valid.
ready_o  out  1  incoming flit accepted this cycle.
vc_id_o  out  VC_W  VC of the outgoing flit.
fdata_o  out  FLIT_W  outgoing flit.
valid_o  out  1  outgoing flit valid.
ready_i  in  1  downstream accepts the outgoing flit.
ocup_o  out  NUM_VC*OCC_W  per-VC occupancy; VC v occupies bits [v*OCC_W +: OCC_W].
locked_o  out  NUM_VC  per-VC packet-in-progress flags.
error_o  out  1  one-cycle protocol-error pulse.

Behaviour:
- Reset: arst is sampled only on the clock edge (synchronous, active-high). When asserted, every FIFO pointer, ocup_o, locked_o, error_o and the arbiter pointer clear to 0. Consequently valid_o=0, fdata_o=0, vc_id_o=0 and ready_o=0 while arst is high. Reset mid-packet discards all stored flits and all locks.
- Flit type field, t = fdata_i[FLIT_W-1:FLIT_W-2]:
  - 00: head.
  - 01 or 10: body.
  - 11: tail.
- Input acceptance, for v = vc_id_i:
  - ready_o = ~full[v] & ~(t==00 & locked[v]).
  - ready_o is combinational from registered state and fdata_i/vc_id_i only; it never depends on ready_i, so there is no full-FIFO bypass.
  - A write occurs when valid_i & ready_o; the flit is stored at wr_ptr[v] and wr_ptr[v] increments with wrap.
- Lock, per VC:
  - An accepted head sets locked[v].
  - An accepted tail clears locked[v].
  - An accepted body leaves locked[v] unchanged.
  - A head+tail in the same flit is not supported.
- Errors: error_o pulses high for the cycle after an accepted body or tail arrives on an unlocked VC. That flit is still stored.
- Full/empty: pointers are log2(DEPTH)+1 bits.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
  - ocup_o[v] = wr_ptr[v] - rd_ptr[v], with a range of 0..DEPTH.
- Output:
  - valid_o = 1 when any VC is non-empty.
  - fdata_o/vc_id_o present the head-of-FIFO of the granted VC, combinationally.
  - When valid_o=0, fdata_o and vc_id_o are driven to 0.
- Arbitration:
  - Round-robin, starting from rr_ptr and picking the first non-empty VC.
  - The grant is held stable while valid_o & ~ready_i; a newly non-empty VC cannot steal an un-accepted output.
  - On transfer (valid_o & ready_i), rd_ptr of the granted VC increments and rr_ptr moves to granted+1, mod NUM_VC.
  - The output may interleave flits of different VCs.
- Latency: a written flit is visible on the output the cycle after its write; there is no fall-through.
- Simultaneous read and write on the same VC in one cycle: both take effect, and occupancy is unchanged. A full VC still refuses the write in that cycle.
- Ordering: flits within one VC leave in arrival order.

Test Plan:
- Reset, then idle: assert arst for 2 cycles -> valid_o=0, ready_o=0, ocup_o=0, locked_o=0. After release, with valid_i=0 -> ready_o=1 for any vc_id_i.
- Fill one VC: write 4 flits to VC2 (head, body, body, body) with ready_i=0 -> ocup_o[VC2]=4 and locked_o[2]=1. A 5th body on VC2 -> ready_o=0 and is not stored. A body on VC1 in the same state -> ready_o=1.
- Lock rule: head on VC0, then a second head on VC0 -> ready_o=0. Send a tail on VC0 -> accepted and locked_o[0]=0. Retry the head -> ready_o=1.
- Round-robin: preload one flit each on VC0, VC1 and VC3; hold ready_i=1 -> vc_id_o sequence 0,1,3. Write a new flit to VC0 during this -> it emerges after VC3, not before.
- Backpressure stability: valid_o=1 on VC1 and ready_i=0 for 3 cycles while VC0 is written -> vc_id_o and fdata_o stay unchanged. On ready_i=1, the VC1 flit transfers.
- Simultaneous events and error: VC3 holding 2 flits, with a read and a write in the same cycle -> ocup_o[VC3] stays 2. A body on unlocked VC2 -> stored, and error_o=1 for exactly one cycle.
